// File: rtl/ram_pkg.sv
// Shared sizing for the 16x8 dual-port RAM and its FIFO controller.
package ram_pkg;
  localparam int unsigned RAM_AW    = 4;
  localparam int unsigned RAM_DW    = 8;
  localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;
endpackage

// File: rtl/fifo_ctrl_16x8_if.sv
// User handshake and RAM-side bus of the FIFO controller.
interface fifo_ctrl_16x8_if
  import ram_pkg::*;
#(
  parameter int unsigned AW = RAM_AW,
  parameter int unsigned DW = RAM_DW
) ();
  logic          push;
  logic          pop;
  logic          flush;
  logic [DW-1:0] din;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_din;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, pop, flush, din,
    input  ram_wr_en, ram_wr_addr, ram_din, ram_rd_en, ram_rd_addr,
    input  dout_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  push, pop, flush, din,
    output ram_wr_en, ram_wr_addr, ram_din, ram_rd_en, ram_rd_addr,
    output dout_valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_16x8_ptr.sv
// Wrapping FIFO pointer, one bit wider than the RAM address.
module fifo_ptr
  import ram_pkg::*;
#(
  parameter int unsigned PW = RAM_AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_flush,
  output logic [PW-1:0] o_ptr
);
  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/fifo_ctrl_16x8_wrap.sv
// Test wrapper joining the FIFO controller to the 16x8 dual-port RAM.
module fifo_ctrl_16x8_wrap
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [RAM_DW-1:0] i_din,
  output logic [RAM_DW-1:0] o_dout,
  output logic              o_dout_valid,
  output logic              o_full,
  output logic              o_empty,
  output logic [RAM_AW:0]   o_count,
  output logic              o_overflow,
  output logic              o_underflow
);
  fifo_ctrl_16x8_if #(.AW(RAM_AW), .DW(RAM_DW)) w_bus ();

  assign w_bus.push  = i_push;
  assign w_bus.pop   = i_pop;
  assign w_bus.flush = i_flush;
  assign w_bus.din   = i_din;

  fifo_ctrl_16x8 #(.AW(RAM_AW), .DW(RAM_DW)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .bus(w_bus)
  );

  ram_dp_16x8 #(.AW(RAM_AW), .DW(RAM_DW)) u_ram (
    .clk      (clk),
    .i_wr_en  (w_bus.ram_wr_en),
    .i_wr_addr(w_bus.ram_wr_addr),
    .i_din    (w_bus.ram_din),
    .i_rd_en  (w_bus.ram_rd_en),
    .i_rd_addr(w_bus.ram_rd_addr),
    .o_dout   (o_dout)
  );

  assign o_dout_valid = w_bus.dout_valid;
  assign o_full       = w_bus.full;
  assign o_empty      = w_bus.empty;
  assign o_count      = w_bus.count;
  assign o_overflow   = w_bus.overflow;
  assign o_underflow  = w_bus.underflow;
endmodule

// File: rtl/ram_dp_16x8.sv
// Simple dual-port RAM, registered read; a same-address write returns the old word.
module ram_dp_16x8
  import ram_pkg::*;
#(
  parameter int unsigned AW = RAM_AW,
  parameter int unsigned DW = RAM_DW
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_din,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_dout
);
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_din;
    if (i_rd_en) r_dout <= r_mem[i_rd_addr];
  end

  assign o_dout = r_dout;
endmodule

// File: rtl/fifo_ctrl_16x8.sv
// FIFO controller for an external 1-cycle-latency dual-port RAM; holds no data.
module fifo_ctrl_16x8
  import ram_pkg::*;
#(
  parameter int unsigned AW = RAM_AW,
  parameter int unsigned DW = RAM_DW
) (
  input logic              clk,
  input logic              rst,
  fifo_ctrl_16x8_if.slave  bus
);
  logic [AW:0]   w_wr_ptr;
  logic [AW:0]   w_rd_ptr;
  logic [DW-1:0] w_din;
  logic          w_block;
  logic          w_full;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          r_dout_valid;
  logic          r_overflow;
  logic          r_underflow;

  assign w_block = rst | bus.flush;
  assign w_empty = (w_wr_ptr == w_rd_ptr);
  assign w_full  = (w_wr_ptr[AW] != w_rd_ptr[AW]) &&
                   (w_wr_ptr[AW-1:0] == w_rd_ptr[AW-1:0]);

  // A full FIFO is never empty, so a pop alongside frees the slot the push reuses.
  assign w_pop_ok  = bus.pop & ~w_empty & ~w_block;
  assign w_push_ok = bus.push & (~w_full | bus.pop) & ~w_block;

  fifo_ptr #(.PW(AW + 1)) u_wr_ptr (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_push_ok),
    .i_flush(bus.flush),
    .o_ptr  (w_wr_ptr)
  );

  fifo_ptr #(.PW(AW + 1)) u_rd_ptr (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_pop_ok),
    .i_flush(bus.flush),
    .o_ptr  (w_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (bus.flush) begin
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_dout_valid <= w_pop_ok;
      if (bus.push && !w_push_ok) r_overflow  <= 1'b1;
      if (bus.pop  && !w_pop_ok)  r_underflow <= 1'b1;
    end
  end

  assign w_din           = bus.din;
  assign bus.ram_din     = w_din;
  assign bus.ram_wr_en   = w_push_ok;
  assign bus.ram_wr_addr = w_wr_ptr[AW-1:0];
  assign bus.ram_rd_en   = w_pop_ok;
  assign bus.ram_rd_addr = w_rd_ptr[AW-1:0];
  assign bus.dout_valid  = r_dout_valid;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.count       = w_wr_ptr - w_rd_ptr;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
endmodule

// File: tb/tb_fifo_ctrl_16x8.sv
// Self-checking bench: directed table, corner-case sequences, random traffic vs a queue model.
module tb_fifo_ctrl_16x8;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [RAM_DW-1:0] ram_dout;

  fifo_ctrl_16x8_if #(.AW(RAM_AW), .DW(RAM_DW)) bus ();

  fifo_ctrl_16x8 #(.AW(RAM_AW), .DW(RAM_DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  ram_dp_16x8 #(.AW(RAM_AW), .DW(RAM_DW)) u_ram (
    .clk      (clk),
    .i_wr_en  (bus.ram_wr_en),
    .i_wr_addr(bus.ram_wr_addr),
    .i_din    (bus.ram_din),
    .i_rd_en  (bus.ram_rd_en),
    .i_rd_addr(bus.ram_rd_addr),
    .o_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a queue of stored words plus accepted push/pop counts since reset/flush.
  logic [7:0] mq[$];
  int         wcnt, rcnt;
  bit         m_ovf, m_udf, m_valid;
  logic [7:0] m_dout;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic bit exp_pop();
    return !rst && !bus.flush && bus.pop && (mq.size() > 0);
  endfunction

  function automatic bit exp_push();
    return !rst && !bus.flush && bus.push && ((mq.size() < RAM_DEPTH) || exp_pop());
  endfunction

  task automatic check_model();
    bit ep, eq;
    ep = exp_push();
    eq = exp_pop();
    chk("count", int'(bus.count), mq.size());
    chk("full", int'(bus.full), int'(mq.size() == RAM_DEPTH));
    chk("empty", int'(bus.empty), int'(mq.size() == 0));
    chk("overflow", int'(bus.overflow), int'(m_ovf));
    chk("underflow", int'(bus.underflow), int'(m_udf));
    chk("dout_valid", int'(bus.dout_valid), int'(m_valid));
    if (m_valid) chk("dout", int'(ram_dout), int'(m_dout));
    chk("ram_wr_en", int'(bus.ram_wr_en), int'(ep));
    if (ep) chk("ram_wr_addr", int'(bus.ram_wr_addr), wcnt % RAM_DEPTH);
    chk("ram_rd_en", int'(bus.ram_rd_en), int'(eq));
    if (eq) chk("ram_rd_addr", int'(bus.ram_rd_addr), rcnt % RAM_DEPTH);
    chk("ram_din", int'(bus.ram_din), int'(bus.din));
  endtask

  task automatic model_update();
    bit ep, eq;
    ep = exp_push();
    eq = exp_pop();
    if (rst || bus.flush) begin
      mq.delete();
      wcnt = 0; rcnt = 0;
      m_ovf = 0; m_udf = 0; m_valid = 0;
    end else begin
      if (bus.push && !ep) m_ovf = 1;
      if (bus.pop && !eq)  m_udf = 1;
      m_valid = eq;
      if (eq) begin
        m_dout = mq.pop_front();
        rcnt++;
      end
      if (ep) begin
        mq.push_back(bus.din);
        wcnt++;
      end
    end
  endtask

  task automatic drive(input bit r, input bit p, input bit q, input bit f, input logic [7:0] d);
    @(negedge clk);
    rst = r; bus.push = p; bus.pop = q; bus.flush = f; bus.din = d;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic step(input bit r, input bit p, input bit q, input bit f, input logic [7:0] d);
    drive(r, p, q, f, d);
    tick();
  endtask

  typedef struct {
    bit rst, push, pop, flush;
    logic [7:0] din;
    bit e_wr, e_rd;
    int e_cnt;
    bit e_empty, e_udf;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 8'h01, 0, 0, 0, 1, 0};
    tbl[1]  = '{0, 1, 1, 0, 8'h5C, 1, 0, 0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 1};
    tbl[3]  = '{0, 0, 1, 0, 8'h00, 0, 1, 1, 0, 1};
    tbl[4]  = '{0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 1};
    tbl[5]  = '{0, 1, 0, 1, 8'h33, 0, 0, 0, 1, 1};
    tbl[6]  = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0};
    tbl[7]  = '{0, 1, 0, 0, 8'h44, 1, 0, 0, 1, 0};
    tbl[8]  = '{0, 1, 1, 0, 8'h55, 1, 1, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0};
    tbl[10] = '{1, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0};

    rst = 1; bus.push = 0; bus.pop = 0; bus.flush = 0; bus.din = '0;
    @(negedge clk);
    tick();

    // Reset state
    drive(0, 0, 0, 0, 8'h00);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_dout_valid", int'(bus.dout_valid), 0);
    chk("rst_ovf", int'(bus.overflow), 0);
    chk("rst_udf", int'(bus.underflow), 0);
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].flush, tbl[i].din);
      chk($sformatf("tbl%0d_wr_en", i), int'(bus.ram_wr_en), int'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_rd_en", i), int'(bus.ram_rd_en), int'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_count", i), int'(bus.count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_empty", i), int'(bus.empty), int'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_udf", i), int'(bus.underflow), int'(tbl[i].e_udf));
      tick();
    end

    // Fill 16 words, addresses in order
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 0, 8'(8'h11 + i));
      chk("fill_wr_addr", int'(bus.ram_wr_addr), i);
      tick();
    end
    drive(0, 0, 0, 0, 8'h00);
    chk("fill_full", int'(bus.full), 1);
    chk("fill_count", int'(bus.count), 16);
    tick();

    // Drain 16 words
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 0, 8'h00);
      chk("drain_rd_addr", int'(bus.ram_rd_addr), i);
      if (i > 0) chk("drain_data", int'(ram_dout), 'h11 + i - 1);
      tick();
    end
    drive(0, 0, 0, 0, 8'h00);
    chk("drain_valid", int'(bus.dout_valid), 1);
    chk("drain_last", int'(ram_dout), 'h20);
    chk("drain_empty", int'(bus.empty), 1);
    tick();

    // Overflow on push while full; push+pop while full accepted
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 8'(8'h60 + i));
    drive(0, 1, 0, 0, 8'hAA);
    chk("ovf_wr_en", int'(bus.ram_wr_en), 0);
    tick();
    drive(0, 1, 1, 0, 8'hBB);
    chk("ovf_flag", int'(bus.overflow), 1);
    chk("ovf_count", int'(bus.count), 16);
    chk("full_pushpop_wr", int'(bus.ram_wr_en), 1);
    chk("full_pushpop_rd", int'(bus.ram_rd_en), 1);
    tick();
    drive(0, 0, 0, 0, 8'h00);
    chk("full_pushpop_count", int'(bus.count), 16);
    tick();

    // Pop on empty with push 0x5C
    step(0, 0, 0, 1, 8'h00);
    drive(0, 1, 1, 0, 8'h5C);
    chk("udf_wr_en", int'(bus.ram_wr_en), 1);
    chk("udf_rd_en", int'(bus.ram_rd_en), 0);
    tick();
    drive(0, 0, 0, 0, 8'h00);
    chk("udf_count", int'(bus.count), 1);
    chk("udf_flag", int'(bus.underflow), 1);
    chk("udf_no_valid", int'(bus.dout_valid), 0);
    tick();

    // Fill 8, pop 8, push 12: write address wraps
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 8'(8'h80 + i));
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 0, 0, 8'(8'hC0 + i));
      chk("wrap_wr_addr", int'(bus.ram_wr_addr), (8 + i) % 16);
      tick();
    end
    drive(0, 0, 0, 0, 8'h00);
    chk("wrap_count", int'(bus.count), 12);
    tick();
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    chk("wrap_last", int'(ram_dout), 'hCB);
    tick();

    // Flush with count 5 and overflow set; pop just before flush still valid
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 8'(8'h30 + i));
    for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 8'h00);
    drive(0, 1, 1, 1, 8'h77);
    chk("flush_pre_count", int'(bus.count), 5);
    chk("flush_pre_ovf", int'(bus.overflow), 1);
    chk("flush_late_valid", int'(bus.dout_valid), 1);
    chk("flush_wr_en", int'(bus.ram_wr_en), 0);
    tick();
    drive(0, 0, 0, 0, 8'h00);
    chk("flush_count", int'(bus.count), 0);
    chk("flush_empty", int'(bus.empty), 1);
    chk("flush_ovf", int'(bus.overflow), 0);
    tick();
    step(0, 1, 0, 0, 8'h12);
    drive(1, 1, 0, 0, 8'h13);
    chk("rst_push_wr_en", int'(bus.ram_wr_en), 0);
    tick();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      int pp, pq;
      case ((i / 50) % 3)
        0:       begin pp = 80; pq = 25; end
        1:       begin pp = 25; pq = 80; end
        default: begin pp = 55; pq = 55; end
      endcase
      step(bit'($urandom_range(0, 199) == 0),
           bit'($urandom_range(0, 99) < pp),
           bit'($urandom_range(0, 99) < pq),
           bit'($urandom_range(0, 59) == 0),
           8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
